// File: rtl/sound_request_sequencer.sv
// sound_request_sequencer: latches audio request edges and plays pending sounds one at a time by priority.
module sound_request_sequencer #(
  parameter int CLKS_PER_MS = 50000,
  parameter int GAP_MS = 10
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       keyXAudioRequest,
  input  logic       keyYAudioRequest,
  input  logic       keyEnterAudioRequest,
  input  logic       holeColAudioRequest,
  input  logic       borderColAudioRequest,
  input  logic       ballToBallColAudioRequest,
  output logic [3:0] freqIndex,
  output logic       toneEnable,
  output logic       busy,
  output logic [2:0] activeSound
);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  localparam int PW = CLKS_PER_MS > 1 ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLKS_PER_MS - 1);
  localparam logic [6:0] GAP_LAST = 7'(GAP_MS - 1);
  state_t state, stateNext;
  logic [5:0] reqNow, reqPrev, rise, pending, pendingNext;
  logic [2:0] sound, soundNext, sel;
  logic [1:0] note, noteNext;
  logic [PW-1:0] pre, preNext;
  logic [6:0] ms, msNext;
  logic [3:0] freqNext;
  logic wrap, done, lastNote;
  function automatic logic [3:0] romNote(input logic [2:0] s, input logic [1:0] n);
    case (s)
      3'd0: romNote = n == 2'd0 ? 4'd7 : n == 2'd1 ? 4'd4 : 4'd0;
      3'd1: romNote = 4'd9;
      3'd2: romNote = 4'd2;
      3'd3: romNote = n == 2'd0 ? 4'd0 : 4'd7;
      3'd4: romNote = 4'd5;
      default: romNote = 4'd4;
    endcase
  endfunction
  function automatic logic [6:0] romDur(input logic [2:0] s);
    case (s)
      3'd0: romDur = 7'd100;
      3'd1, 3'd2: romDur = 7'd40;
      3'd3: romDur = 7'd60;
      default: romDur = 7'd20;
    endcase
  endfunction
  function automatic logic [1:0] romCount(input logic [2:0] s);
    romCount = s == 3'd0 ? 2'd3 : s == 3'd3 ? 2'd2 : 2'd1;
  endfunction
  // bit index equals priority code: 0 = hole (highest) .. 5 = keyX
  assign reqNow = {keyXAudioRequest, keyYAudioRequest, keyEnterAudioRequest,
                   borderColAudioRequest, ballToBallColAudioRequest, holeColAudioRequest};
  always_comb begin
    rise = reqNow & ~reqPrev;
    sel = pending[0] ? 3'd0 : pending[1] ? 3'd1 : pending[2] ? 3'd2 :
          pending[3] ? 3'd3 : pending[4] ? 3'd4 : 3'd5;
    wrap = pre == PRE_MAX;
    done = wrap && ms == (state == PLAY ? romDur(sound) - 7'd1 : GAP_LAST);
    lastNote = note == romCount(sound) - 2'd1;
    stateNext = state;
    soundNext = sound;
    noteNext = note;
    freqNext = freqIndex;
    pendingNext = pending | rise;
    preNext = wrap ? '0 : pre + PW'(1);
    msNext = ms + {6'd0, wrap};
    case (state)
      IDLE: begin
        preNext = '0;
        msNext = '0;
        if (|pending) begin
          stateNext = PLAY;
          soundNext = sel;
          noteNext = 2'd0;
          freqNext = romNote(sel, 2'd0);
          pendingNext = (pending & ~(6'd1 << sel)) | rise;
        end
      end
      PLAY: if (done) begin
        stateNext = GAP;
        preNext = '0;
        msNext = '0;
      end
      GAP: if (done) begin
        preNext = '0;
        msNext = '0;
        stateNext = lastNote ? IDLE : PLAY;
        noteNext = lastNote ? note : note + 2'd1;
        freqNext = lastNote ? freqIndex : romNote(sound, note + 2'd1);
      end
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      reqPrev <= '0;
      pending <= '0;
      sound <= '0;
      note <= '0;
      pre <= '0;
      ms <= '0;
      freqIndex <= '0;
      toneEnable <= 1'b0;
      busy <= 1'b0;
      activeSound <= 3'd7;
    end else begin
      state <= stateNext;
      reqPrev <= reqNow;
      pending <= pendingNext;
      sound <= soundNext;
      note <= noteNext;
      pre <= preNext;
      ms <= msNext;
      freqIndex <= freqNext;
      toneEnable <= stateNext == PLAY;
      busy <= stateNext != IDLE;
      activeSound <= stateNext == IDLE ? 3'd7 : soundNext;
    end
  end
endmodule

// File: tb/tb_sound_request_sequencer.sv
// tb_sound_request_sequencer: randomized and directed checks against a timeline model of the sequencer.
module tb_sound_request_sequencer;
  localparam int C = 4, G = 10;
  logic clk = 0, resetN = 0;
  logic [5:0] req = '0;
  logic [3:0] freqIndex;
  logic toneEnable, busy;
  logic [2:0] activeSound;
  int vectors = 0, errors = 0;
  logic [5:0] mPend, mPrev;
  bit mBusy, mTone;
  int mStart, mSnd, cyc;
  logic [3:0] mFreq;
  logic [8:0] expOut;
  int noteTab[6][3] = '{'{7, 4, 0}, '{9, 0, 0}, '{2, 0, 0}, '{0, 7, 0}, '{5, 0, 0}, '{4, 0, 0}};
  int durTab[6][3] = '{'{100, 100, 100}, '{40, 0, 0}, '{40, 0, 0}, '{60, 60, 0}, '{20, 0, 0}, '{20, 0, 0}};
  int cntTab[6] = '{3, 1, 1, 2, 1, 1};
  always #5 clk = ~clk;
  sound_request_sequencer #(.CLKS_PER_MS(C), .GAP_MS(G)) dut (
    .clk(clk), .resetN(resetN),
    .keyXAudioRequest(req[5]), .keyYAudioRequest(req[4]), .keyEnterAudioRequest(req[3]),
    .holeColAudioRequest(req[0]), .borderColAudioRequest(req[2]), .ballToBallColAudioRequest(req[1]),
    .freqIndex(freqIndex), .toneEnable(toneEnable), .busy(busy), .activeSound(activeSound)
  );
  function automatic int seqLen(int s);
    int t = 0;
    for (int i = 0; i < cntTab[s]; i++) t += (durTab[s][i] + G) * C;
    return t;
  endfunction
  task automatic modelReset();
    mPend = '0; mPrev = '0; mBusy = 0; mTone = 0; mFreq = '0; mSnd = 0; mStart = 0;
    expOut = 9'h070;
  endtask
  // whole-sequence timeline: position within the sound is derived from cycles since its start
  task automatic tick(input logic [5:0] r);
    logic [5:0] rise;
    int off, seg;
    bit found;
    req = r;
    @(posedge clk);
    cyc++;
    rise = req & ~mPrev;
    mPrev = req;
    if (mBusy) begin
      if (cyc - mStart == seqLen(mSnd)) mBusy = 0;
    end else if (mPend != 0) begin
      for (int i = 5; i >= 0; i--) if (mPend[i]) mSnd = i;
      mPend[mSnd] = 1'b0;
      mStart = cyc;
      mBusy = 1;
    end
    mPend |= rise;
    mTone = 0;
    if (mBusy) begin
      off = cyc - mStart;
      found = 0;
      for (int i = 0; i < cntTab[mSnd]; i++) begin
        seg = (durTab[mSnd][i] + G) * C;
        if (!found && off < seg) begin
          mTone = off < durTab[mSnd][i] * C;
          mFreq = 4'(noteTab[mSnd][i]);
          found = 1;
        end else if (!found) off -= seg;
      end
    end
    expOut = {mBusy, mTone, mBusy ? 3'(mSnd) : 3'd7, mFreq};
    #1;
  endtask
  task automatic test_reset();
    vectors++;
    if ({busy, toneEnable, activeSound, freqIndex} !== 9'h070) begin
      errors++;
      $display("FAIL reset_initial: got %h want 070", {busy, toneEnable, activeSound, freqIndex});
    end
    #3 resetN = 1;
    for (int i = 0; i < 40; i++) begin
      tick(i == 3 ? 6'b000001 : i == 10 ? 6'b100000 : 6'b0);
      vectors++;
      if ({busy, toneEnable, activeSound, freqIndex} !== expOut) begin
        errors++;
        $display("FAIL reset_pre: cyc %0d got %h want %h", cyc, {busy, toneEnable, activeSound, freqIndex}, expOut);
      end
    end
    #2 resetN = 0;
    #1 vectors++;
    if ({busy, toneEnable, activeSound, freqIndex} !== 9'h070) begin
      errors++;
      $display("FAIL reset_async: got %h want 070", {busy, toneEnable, activeSound, freqIndex});
    end
    modelReset();
    #3 resetN = 1;
    for (int i = 0; i < 200; i++) begin
      tick(6'b0);
      vectors++;
      if ({busy, toneEnable, activeSound, freqIndex} !== expOut) begin
        errors++;
        $display("FAIL reset_after: cyc %0d got %h want %h", cyc, {busy, toneEnable, activeSound, freqIndex}, expOut);
      end
    end
  endtask
  task automatic test_single_keyx();
    int busyCnt = 0, toneCnt = 0;
    for (int i = 0; i < 140; i++) begin
      tick(i == 0 ? 6'b100000 : 6'b0);
      busyCnt += int'(busy);
      toneCnt += int'(toneEnable);
      vectors++;
      if ({busy, toneEnable, activeSound, freqIndex} !== expOut) begin
        errors++;
        $display("FAIL keyx: cyc %0d got %h want %h", cyc, {busy, toneEnable, activeSound, freqIndex}, expOut);
      end
    end
    vectors++;
    if (busyCnt !== 120 || toneCnt !== 80) begin
      errors++;
      $display("FAIL keyx_len: busy %0d tone %0d want 120 80", busyCnt, toneCnt);
    end
  endtask
  task automatic test_hole();
    int busyCnt = 0;
    for (int i = 0; i < 1340; i++) begin
      tick(i == 0 ? 6'b000001 : 6'b0);
      busyCnt += int'(busy);
      vectors++;
      if ({busy, toneEnable, activeSound, freqIndex} !== expOut) begin
        errors++;
        $display("FAIL hole: cyc %0d got %h want %h", cyc, {busy, toneEnable, activeSound, freqIndex}, expOut);
      end
    end
    vectors++;
    if (busyCnt !== 1320) begin
      errors++;
      $display("FAIL hole_len: busy %0d want 1320", busyCnt);
    end
  endtask
  task automatic test_simultaneous();
    int order[$];
    logic [2:0] last = 3'd7;
    for (int i = 0; i < 1700; i++) begin
      tick(i == 0 ? 6'b100101 : 6'b0);
      if (activeSound != last && activeSound != 3'd7) order.push_back(int'(activeSound));
      last = activeSound;
      vectors++;
      if ({busy, toneEnable, activeSound, freqIndex} !== expOut) begin
        errors++;
        $display("FAIL simul: cyc %0d got %h want %h", cyc, {busy, toneEnable, activeSound, freqIndex}, expOut);
      end
    end
    vectors++;
    if (order.size() != 3 || order[0] != 0 || order[1] != 2 || order[2] != 5) begin
      errors++;
      $display("FAIL simul_order: got %p want 0 2 5", order);
    end
  endtask
  task automatic test_merge_replay();
    int starts = 0;
    logic prevBusy = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(i < 500 || i == 600 || i == 620 || i == 640 || i == 660 ? 6'b010000 : 6'b0);
      starts += int'(busy && !prevBusy);
      prevBusy = busy;
      vectors++;
      if ({busy, toneEnable, activeSound, freqIndex} !== expOut) begin
        errors++;
        $display("FAIL merge: cyc %0d got %h want %h", cyc, {busy, toneEnable, activeSound, freqIndex}, expOut);
      end
    end
    vectors++;
    if (starts !== 3) begin
      errors++;
      $display("FAIL merge_count: plays %0d want 3", starts);
    end
  endtask
  task automatic test_no_preempt();
    int order[$];
    logic [2:0] last = 3'd7;
    for (int i = 0; i < 2000; i++) begin
      tick(i == 0 ? 6'b001000 : i == 100 ? 6'b000001 : 6'b0);
      if (activeSound != last && activeSound != 3'd7) order.push_back(int'(activeSound));
      last = activeSound;
      vectors++;
      if ({busy, toneEnable, activeSound, freqIndex} !== expOut) begin
        errors++;
        $display("FAIL nopreempt: cyc %0d got %h want %h", cyc, {busy, toneEnable, activeSound, freqIndex}, expOut);
      end
    end
    vectors++;
    if (order.size() != 2 || order[0] != 3 || order[1] != 0) begin
      errors++;
      $display("FAIL nopreempt_order: got %p want 3 0", order);
    end
  endtask
  task automatic test_random();
    logic [5:0] r;
    for (int i = 0; i < 8000; i++) begin
      r = $urandom_range(0, 59) == 0 ? 6'($urandom) : 6'b0;
      tick(r);
      vectors++;
      if ({busy, toneEnable, activeSound, freqIndex} !== expOut) begin
        errors++;
        $display("FAIL random: cyc %0d got %h want %h", cyc, {busy, toneEnable, activeSound, freqIndex}, expOut);
      end
    end
  endtask
  initial begin
    cyc = 0;
    modelReset();
    #22;
    test_reset();
    test_single_keyx();
    test_hole();
    test_simultaneous();
    test_merge_replay();
    test_no_preempt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
